prim_reg_slice: RTL and testbench

Single-clock valid/ready register slice (two-entry skid buffer) that cuts all combinational paths between an upstream producer and a downstream consumer. It sits on handshaked datapaths wherever a plain flop stage would break backpressure: both `out_valid_o`/`out_data_o` and `in_ready_o` are driven directly from flops. It sustains full throughput with one cycle of forward latency.

---
 rtl/prim_reg_slice_pkg.sv | 11 +
 rtl/prim_flop.sv | 20 ++
 rtl/prim_reg_slice.sv | 108 ++++++++++
 tb/tb_prim_reg_slice.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/prim_reg_slice_pkg.sv
// Shared types for the valid/ready register slice.
package prim_reg_slice_pkg;

  // The encoding doubles as the occupancy count driven on depth_o.
  typedef enum logic [1:0] {
    RsEmpty = 2'b00,
    RsOne   = 2'b01,
    RsFull  = 2'b10
  } rs_state_e;

endpackage

// File: rtl/prim_flop.sv
// Plain resettable data register used for the slice's main and skid entries.
module prim_flop #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= ResetValue;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/prim_reg_slice.sv
// Two-entry skid buffer: every output comes straight from a flop, so no
// combinational path crosses the slice in either direction.
//
//   state   | meaning
//   RsEmpty | nothing held, out_valid_o=0
//   RsOne   | main entry valid
//   RsFull  | main and skid valid, in_ready_o=0
module prim_reg_slice
  import prim_reg_slice_pkg::*;
#(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       depth_o
);

  rs_state_e        state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic             in_fire, out_fire;
  logic             load_main, main_from_skid, load_skid;
  logic [Width-1:0] main_q, main_d, skid_q, skid_d;

  always_comb begin
    in_fire        = in_valid_i & in_ready_q;
    out_fire       = out_valid_q & out_ready_i;
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      RsEmpty: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = RsOne;
        end
      end
      RsOne: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = RsFull;
        end else if (out_fire) begin
          state_d = RsEmpty;
        end
      end
      RsFull: begin
        // in_ready_o is low here, so only a drain can happen.
        if (out_fire) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = RsOne;
        end
      end
      default: state_d = RsEmpty;
    endcase
  end

  // Handshake outputs are registered from the next state rather than decoded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RsEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != RsEmpty);
      in_ready_q  <= (state_d != RsFull);
    end
  end

  assign main_d = load_main ? (main_from_skid ? skid_q : in_data_i) : main_q;
  assign skid_d = load_skid ? in_data_i : skid_q;

  prim_flop #(
    .Width      (Width),
    .ResetValue (ResetValue)
  ) u_main (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  prim_flop #(
    .Width      (Width),
    .ResetValue (ResetValue)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (skid_d),
    .q_o    (skid_q)
  );

  assign out_valid_o = out_valid_q;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = main_q;
  assign depth_o     = state_q;

endmodule

// File: tb/tb_prim_reg_slice.sv
// Bench for prim_reg_slice: directed vector table, hand sequences and a
// randomized run against a queue-based FIFO model.
module tb_prim_reg_slice;

  localparam int         W   = 8;
  localparam logic [7:0] RV  = 8'h3C;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic [W-1:0] in_data_i;
  logic         in_ready_o;
  logic         out_valid_o;
  logic [W-1:0] out_data_o;
  logic         out_ready_i;
  logic [1:0]   depth_o;

  int total = 0;
  int bad   = 0;
  int transfers = 0;

  logic [7:0] q[$];
  logic [7:0] exp_data;

  always #5 clk_i = ~clk_i;

  prim_reg_slice #(
    .Width      (W),
    .ResetValue (RV)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .depth_o     (depth_o)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ready;
    logic [1:0] e_depth;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_data = RV;
  endtask

  // Called at posedge+1: apply inputs, cross one edge, update the FIFO model.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r);
    bit inf, outf;
    logic [7:0] popped;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    inf  = v && (q.size() < 2);
    outf = r && (q.size() > 0);
    @(posedge clk_i);
    #1;
    if (outf) begin
      popped = q.pop_front();
      transfers++;
    end
    if (inf) q.push_back(d);
    if (q.size() > 0) exp_data = q[0];
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'(q.size() > 0));
    check({tag, "_in_ready"},  32'(in_ready_o),  32'(q.size() < 2));
    check({tag, "_depth"},     32'(depth_o),     32'(q.size()));
    check({tag, "_out_data"},  32'(out_data_o),  32'(exp_data));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready_o),  32'd1);
    check({tag, "_depth"},     32'(depth_o),     32'd0);
    check({tag, "_out_data"},  32'(out_data_o),  32'(RV));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0, 2'd2};
    vecs[2]  = '{1'b1, 8'hEE, 1'b0, 1'b1, 8'hA5, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 2'd0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1};
    vecs[7]  = '{1'b0, 8'h33, 1'b1, 1'b0, 8'h22, 1'b1, 2'd0};
    vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1'b1, 2'd1};
    vecs[9]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b0, 2'd2};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h55, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 2'd0};

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    model_reset();
    #12;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    drive_cycle(1'b0, 8'h00, 1'b0);
    check_reset_outputs("reset_idle");

    for (int i = 0; i < 13; i++) begin
      drive_cycle(vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid_o), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_out_data", i),  32'(out_data_o),  32'(vecs[i].e_data));
      check($sformatf("vec%0d_in_ready", i),  32'(in_ready_o),  32'(vecs[i].e_ready));
      check($sformatf("vec%0d_depth", i),     32'(depth_o),     32'(vecs[i].e_depth));
    end

    for (int i = 1; i <= 16; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b1);
      check($sformatf("stream%0d_data", i),  32'(out_data_o),  32'(i));
      check($sformatf("stream%0d_depth", i), 32'(depth_o),     32'd1);
      check($sformatf("stream%0d_valid", i), 32'(out_valid_o), 32'd1);
    end
    drive_cycle(1'b0, 8'h00, 1'b1);
    check_model("stream_drain");

    // Asynchronous reset while FULL, checked before the next clock edge.
    drive_cycle(1'b1, 8'hAA, 1'b0);
    drive_cycle(1'b1, 8'hBB, 1'b0);
    check("pre_async_depth", 32'(depth_o), 32'd2);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #2;
    rst_ni = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b1);
    check_model("post_rst");

    begin
      int cyc = 0;
      transfers = 0;
      while (transfers < 10000 && cyc < 60000) begin
        drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        check_model("rand");
        cyc++;
      end
      check("rand_transfer_budget", 32'(transfers >= 10000), 32'd1);
    end

    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    check_model("final_drain");
    check("final_depth", 32'(depth_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
